// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS32 control sequencer: Avalon-MM fetch, instruction decode, FETCH/DECODE/EXEC/MEM/WB stepping.
// Optional bus-stall watchdog enabled by defining WAIT_TIMEOUT_EN.
module mips_multicycle_sequencer #(
    parameter logic [31:0] RESET_VECTOR = 32'hBFC00000,
    parameter int unsigned WAIT_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] address,
    output logic        read,
    output logic        write,
    input  logic        waitrequest,
    output logic [31:0] writedata,
    output logic [3:0]  byteenable,
    input  logic [31:0] readdata,
    input  logic [31:0] pc_next,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_be,
    output logic [2:0]  state,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] jaddr,
    output logic [31:0] mem_rdata,
    output logic        wb_en,
    output logic        active,
    output logic        fault
);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXEC    = 3'd2,
        S_MEM     = 3'd3,
        S_WB      = 3'd4,
        S_HALT    = 3'd5,
        S_FAULT   = 3'd6,
        S_ILLEGAL = 3'd7
    } state_t;

    state_t cur;
    logic   timed_out;
    logic   is_store;

    assign opcode   = instr[31:26];
    assign rs       = instr[25:21];
    assign rt       = instr[20:16];
    assign rd       = instr[15:11];
    assign shamt    = instr[10:6];
    assign funct    = instr[5:0];
    assign imm16    = instr[15:0];
    assign jaddr    = instr[25:0];
    assign state    = cur;
    assign is_store = opcode[5] & opcode[3];
    assign active   = (cur != S_HALT) && (cur != S_FAULT);
    assign fault    = (cur == S_FAULT);

`ifdef WAIT_TIMEOUT_EN
    localparam logic [15:0] TIMEOUT_LIMIT = 16'(WAIT_TIMEOUT);
    logic [15:0] wait_cnt;
    logic        in_access;

    assign in_access = (cur == S_FETCH) || (cur == S_MEM);
    assign timed_out = in_access && waitrequest && (wait_cnt == TIMEOUT_LIMIT);

    // Any cycle that is not a stall ends the access, so the next access starts from zero.
    always_ff @(posedge clk) begin
        if (rst || !(in_access && waitrequest)) begin
            wait_cnt <= '0;
        end else begin
            wait_cnt <= wait_cnt + 16'd1;
        end
    end
`else
    assign timed_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            cur       <= S_FETCH;
            pc        <= RESET_VECTOR;
            instr     <= '0;
            mem_rdata <= '0;
        end else begin
            case (cur)
                S_FETCH: begin
                    if (timed_out) begin
                        cur <= S_FAULT;
                    end else if (!waitrequest) begin
                        instr <= readdata;
                        cur   <= S_DECODE;
                    end
                end
                S_DECODE: cur <= S_EXEC;
                S_EXEC:   cur <= opcode[5] ? S_MEM : S_WB;
                S_MEM: begin
                    if (timed_out) begin
                        cur <= S_FAULT;
                    end else if (!waitrequest) begin
                        if (!opcode[3]) mem_rdata <= readdata;
                        cur <= S_WB;
                    end
                end
                S_WB: begin
                    pc  <= pc_next;
                    cur <= (pc_next == '0) ? S_HALT : S_FETCH;
                end
                S_HALT:  cur <= S_HALT;
                S_FAULT: cur <= S_FAULT;
                default: cur <= S_FAULT;
            endcase
        end
    end

    // Bus signals decode from the state register alone, so they hold steady for a whole access.
    always_comb begin
        read       = 1'b0;
        write      = 1'b0;
        address    = '0;
        writedata  = '0;
        byteenable = '0;
        wb_en      = 1'b0;
        case (cur)
            S_FETCH: begin
                read       = ~rst;
                address    = pc;
                byteenable = 4'b1111;
            end
            S_MEM: begin
                address    = mem_addr;
                byteenable = mem_be;
                if (opcode[3]) begin
                    write     = ~rst;
                    writedata = mem_wdata;
                end else begin
                    read = ~rst;
                end
            end
            S_WB:    wb_en = ~is_store;
            default: ;
        endcase
    end

endmodule

// File: doc/mips_multicycle_sequencer.md
# mips_multicycle_sequencer

Parametrised multi-cycle control sequencer for the MIPS32 CPU, the successor to the fixed five-state draft FSM. It fetches instructions over the Avalon-MM master bus with full `waitrequest` handling and latches each instruction into an instruction register. It splits the instruction into R/I/J fields and steps FETCH→DECODE→EXEC→(MEM)→WB, issuing a data-bus access only for load/store opcodes. It sits between the bus interface and the datapath; the datapath supplies the next PC and the data address and write data.

## Interface
- `RESET_VECTOR`, 32'hBFC00000, PC value loaded on reset.
- `WAIT_TIMEOUT`, 255, maximum consecutive `waitrequest` cycles tolerated in one bus access. Used only with `WAIT_TIMEOUT_EN`.
- `clk` in 1: clock. All state changes on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `address` out 32: Avalon address. PC in FETCH, `mem_addr` in MEM, 0 otherwise.
- `read` out 1: Avalon read strobe.
- `write` out 1: Avalon write strobe.
- `waitrequest` in 1: Avalon stall.
- `writedata` out 32: `mem_wdata` in MEM-store, 0 otherwise.
- `byteenable` out 4: 4'b1111 in FETCH, `mem_be` in MEM, 4'b0000 otherwise.
- `readdata` in 32: Avalon read data.
- `pc_next` in 32: next PC from the datapath, sampled in WB.
- `mem_addr` in 32: data address, valid in MEM.
- `mem_wdata` in 32: store data, valid in MEM.
- `mem_be` in 4: data byte enables, valid in MEM.
- `state` out 3: current state encoding.
- `pc` out 32: current PC register.
- `instr` out 32: instruction register.
- `opcode` out 6: `instr[31:26]`.
- `rs` out 5: `instr[25:21]`.
- `rt` out 5: `instr[20:16]`.
- `rd` out 5: `instr[15:11]`.
- `shamt` out 5: `instr[10:6]`.
- `funct` out 6: `instr[5:0]`.
- `imm16` out 16: `instr[15:0]`.
- `jaddr` out 26: `instr[25:0]`.
- `mem_rdata` out 32: load data register.
- `wb_en` out 1: one-cycle register-write strobe.
- `active` out 1: high while not HALT or FAULT.
- `fault` out 1: high in FAULT.

## Operation
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5, FAULT=6. Value 7 is illegal and moves to FAULT on the next edge.
- **FETCH**
  - Drives `read`=1, `address`=`pc`.
  - Stays in FETCH while `waitrequest`=1.
  - On the first edge with `waitrequest`=0: `instr`←`readdata`, then go to DECODE.
- **DECODE** → EXEC unconditionally. The field outputs are combinational slices of `instr` and are valid from DECODE onward.
- **EXEC**
  - If `opcode[5]`=1 (load/store class), go to MEM.
  - Otherwise go to WB.
- **MEM**
  - Store when `opcode[3]`=1: `write`=1, `read`=0.
  - Load when `opcode[3]`=0: `read`=1, `write`=0.
  - Strobes are held until the first edge with `waitrequest`=0. On that edge a load latches `mem_rdata`←`readdata`, then go to WB.
- **WB**
  - `wb_en`=1 except for stores.
  - `pc`←`pc_next`.
  - If `pc_next`==0, go to HALT; otherwise go to FETCH.
- **HALT**: terminal state. `active`=0 and all bus strobes are 0. Only `rst` leaves it.
- `read` and `write` are never high together.
- Outside FETCH and MEM, `address`, `writedata` and `byteenable` are 0.

## Timing
- **Reset values:**
  - `state`=FETCH, `pc`=`RESET_VECTOR`, `instr`=0, `mem_rdata`=0, `wb_en`=0, `fault`=0, `active`=1.
  - While `rst`=1, `read`=`write`=0 (strobes are gated by `rst`).
- **Reset mid-operation:** `rst` overrides every state, including mid-access in FETCH or MEM. The access is abandoned; no latch occurs on that edge.
- **Latency with zero wait states:**
  - Non-memory instruction: 4 cycles.
  - Load/store: 5 cycles.
  - Each `waitrequest` cycle adds 1.
- **`wb_en` pulse:** asserted combinationally in WB, high for exactly one cycle per non-store instruction.
- **Access alignment:** `address` and the strobes change only on state transitions. They are stable for the whole access.

## Configuration
- `WAIT_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to FETCH or MEM and increments each cycle `waitrequest`=1 in those states.
  - When the count reaches `WAIT_TIMEOUT` with `waitrequest` still 1, the next state is FAULT.
  - In FAULT: `fault`=1, `active`=0, strobes 0. Only `rst` exits FAULT.
- `WAIT_TIMEOUT_EN` undefined:
  - The counter is not built and waits are unbounded.
  - FAULT is reachable only via the illegal state 7.

## Test plan
- **ADDIU, no waits:** after reset, `readdata`=32'h241F07C0 with `waitrequest`=0. Expect the `state` sequence 0,1,2,4,0; `address`=32'hBFC00000 in FETCH; `opcode`=6'b001001, `rt`=5'd31, `imm16`=16'h07C0; `wb_en` high exactly 1 cycle.
- **Fetch stall:** `waitrequest`=1 for 3 cycles in FETCH. Expect `read` held high with a stable `address`, `instr` latched on the 4th cycle, total 7 cycles to return to FETCH.
- **LW:** `instr`=32'h8C020004, `mem_addr`=32'h1000, `readdata` in MEM = 32'hDEADBEEF. Expect MEM entered with `read`=1, `address`=32'h1000, `mem_rdata`=32'hDEADBEEF, `wb_en`=1 in WB.
- **SW:** `instr`=32'hAC020004, `mem_wdata`=32'h12345678, `mem_be`=4'b0011. Expect `write`=1, `writedata`=32'h12345678, `byteenable`=4'b0011, `wb_en`=0.
- **Halt:** `pc_next`=0 in WB. Expect HALT, `active`=0, strobes 0 for ≥10 cycles. `rst` then restores `pc`=32'hBFC00000.
- **Timeout (`WAIT_TIMEOUT_EN`, `WAIT_TIMEOUT`=4):** hold `waitrequest`=1. Expect `fault`=1 and `active`=0 after cycle 5 of FETCH. Also assert `rst` mid-MEM stall and expect FETCH with no latch.
